load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 57 +++++
 rtl/load_store_unit_load_align.sv | 49 ++++
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//
// Shared definitions for the RV32I load/store unit:
//   - data/address width
//   - funct3 width/sign encodings for loads and stores
//   - 2-bit FSM state encoding
//   - access_ok(): legality check for funct3/alignment
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam int XLEN = 32;

    // funct3 width/sign encodings (RV32I LOAD/STORE)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10
    } lsu_state_e;

    // True when funct3 is a defined width and the address is naturally
    // aligned for that width. Bytes are always aligned.
    function automatic logic access_ok(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//
// Bundles the three channels around the load/store unit:
//   ex_*   : execute-stage op presentation (valid/ready handshake)
//   mem_*  : data-memory request (req/gnt) and read response (rvalid/rdata)
//   wb_*   : load writeback pulse, plus the misalign reject pulse
//
// Modports:
//   slave  : the load/store unit's view
//   master : the surrounding pipeline/memory view (drives the unit's inputs)
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // Execute stage
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr;
    logic [XLEN-1:0] ex_wdata;
    logic [4:0]      ex_rd;

    // Memory request / response
    logic            mem_req;
    logic            mem_gnt;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    // Writeback / status
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            misalign;

    modport slave (
        input  ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output ex_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_valid, wb_rd, wb_data, misalign
    );

    modport master (
        output ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  ex_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_valid, wb_rd, wb_data, misalign
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//
// Combinational load-data formatter. Picks the addressed byte/halfword out of
// the 32-bit memory word and sign- or zero-extends it according to funct3.
//
// Ports:
//   i_addr_lo [1:0]  : byte offset of the load within the word
//   i_funct3  [2:0]  : load width/sign (B, H, W, BU, HU)
//   i_rdata   [31:0] : raw word returned by memory
//   o_data    [31:0] : register-file ready value
// -----------------------------------------------------------------------------
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select: byte by full offset, halfword by offset bit 1
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the default arm / up-front defaults); a missed path
        // would infer a latch.
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'b0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = i_rdata;   // W
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// RV32I load/store unit sitting between the execute stage and a req/gnt data
// memory. One op in flight at a time:
//   IDLE   : ex_ready = 1; an accepted legal op is latched and moves to REQ,
//            an illegal/misaligned op is dropped with a one-cycle misalign
//   REQ    : mem_req = 1 with fields held until mem_gnt
//            (store -> IDLE, load -> WAIT_R)
//   WAIT_R : wait for mem_rvalid, then register the formatted load result and
//            pulse wb_valid for one cycle
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (ex_*, mem_*, wb_*, misalign)
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    // FSM
    lsu_state_e r_state;
    lsu_state_e w_state_next;

    // Latched op
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [4:0]      r_rd;

    // Memory request fields
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;

    // Writeback / status
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_misalign;

    // Combinational controls
    logic            w_ex_ready;
    logic            w_mem_req;
    logic            w_accept;
    logic            w_legal;
    logic            w_capture;
    logic            w_load_done;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;

    assign w_legal = access_ok(bus.ex_funct3, bus.ex_addr[1:0]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ex_ready   = 1'b0;
        w_mem_req    = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_load_done  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ex_ready = 1'b1;
                if (bus.ex_valid) begin
                    w_accept = 1'b1;
                    // Illegal ops are consumed but never reach memory
                    if (w_legal) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    w_state_next = r_mem_we ? ST_IDLE : ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (bus.mem_rvalid) begin
                    w_load_done  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte enables and store-lane replication from the presented op.
    // Memory writes whichever lanes are enabled, so replicating the
    // narrow datum into every lane removes any shifter on the store path.
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.ex_wdata;
        case (bus.ex_funct3)
            F3_B, F3_BU: begin
                w_be    = 4'b0001 << bus.ex_addr[1:0];
                w_wdata = {4{bus.ex_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                w_be    = 4'b0011 << bus.ex_addr[1:0];
                w_wdata = {2{bus.ex_wdata[15:0]}};
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
    load_align u_load_align (
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .i_rdata   (bus.mem_rdata),
        .o_data    (w_load_data)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3    <= F3_B;
            r_addr_lo   <= 2'b00;
            r_rd        <= 5'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
        end else begin
            // Both are single-cycle pulses: set only by the triggering cycle
            r_misalign <= w_accept & ~w_legal;
            r_wb_valid <= w_load_done;

            if (w_capture) begin
                r_funct3    <= bus.ex_funct3;
                r_addr_lo   <= bus.ex_addr[1:0];
                r_rd        <= bus.ex_rd;
                r_mem_we    <= bus.ex_is_store;
                r_mem_addr  <= {bus.ex_addr[XLEN-1:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end

            if (w_load_done) begin
                r_wb_data <= w_load_data;
                r_wb_rd   <= r_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.ex_ready  = w_ex_ready;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;
    assign bus.misalign  = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Inputs are driven 1 time unit after the
// rising edge, outputs are sampled at the same point (settled, away from the
// edge). Expected values are hand-computed constants in each scenario.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store: accept, hold REQ for gnt_dly cycles, then grant.
    task automatic run_store(input string name, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_dly, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        bus.ex_valid    = 1'b1;
        bus.ex_is_store = 1'b1;
        bus.ex_funct3   = f3;
        bus.ex_addr     = addr;
        bus.ex_wdata    = wdata;
        bus.ex_rd       = 5'd0;
        tick();
        // Scramble inputs: the request must come from latched copies
        bus.ex_valid  = 1'b0;
        bus.ex_addr   = 32'hFFFF_FFFF;
        bus.ex_wdata  = 32'h0;
        bus.ex_funct3 = 3'b111;
        for (int i = 0; i <= gnt_dly; i++) begin
            n_vec++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                 bus.ex_ready, bus.wb_valid} !==
                {1'b1, 1'b1, exp_addr, exp_be, exp_wdata, 1'b0, 1'b0}) begin
                n_miss++;
                $display("FAIL %s req cycle %0d: req=%b we=%b addr=%h be=%b wdata=%h rdy=%b wbv=%b, want req=1 we=1 addr=%h be=%b wdata=%h rdy=0 wbv=0",
                         name, i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
                         bus.mem_wdata, bus.ex_ready, bus.wb_valid, exp_addr, exp_be, exp_wdata);
            end
            if (i == gnt_dly) bus.mem_gnt = 1'b1;
            tick();
        end
        bus.mem_gnt = 1'b0;
        n_vec++;
        if ({bus.mem_req, bus.ex_ready, bus.wb_valid, bus.misalign} !== 4'b0100) begin
            n_miss++;
            $display("FAIL %s done: req=%b rdy=%b wbv=%b mis=%b, want req=0 rdy=1 wbv=0 mis=0",
                     name, bus.mem_req, bus.ex_ready, bus.wb_valid, bus.misalign);
        end
    endtask

    // Load: accept, gnt after gnt_dly REQ cycles, rvalid after rv_dly
    // WAIT_R cycles; checks the single writeback pulse.
    task automatic run_load(input string name, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_data);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        bus.ex_valid    = 1'b1;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = f3;
        bus.ex_addr     = addr;
        bus.ex_wdata    = 32'h0;
        bus.ex_rd       = rd;
        tick();
        bus.ex_valid    = 1'b0;
        bus.ex_addr     = 32'hFFFF_FFFF;
        bus.ex_funct3   = 3'b111;
        bus.ex_rd       = ~rd;
        for (int i = 0; i <= gnt_dly; i++) begin
            n_vec++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.ex_ready, bus.wb_valid} !==
                {1'b1, 1'b0, exp_addr, exp_be, 1'b0, 1'b0}) begin
                n_miss++;
                $display("FAIL %s req cycle %0d: req=%b we=%b addr=%h be=%b rdy=%b wbv=%b, want req=1 we=0 addr=%h be=%b rdy=0 wbv=0",
                         name, i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
                         bus.ex_ready, bus.wb_valid, exp_addr, exp_be);
            end
            // A stray rvalid while still requesting must be ignored
            if (i == gnt_dly) begin
                bus.mem_gnt    = 1'b1;
                bus.mem_rvalid = 1'b0;
            end else begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h0BAD_0BAD;
            end
            tick();
        end
        for (int i = 0; i <= rv_dly; i++) begin
            // gnt held high in WAIT_R must be ignored
            bus.mem_gnt = (i != rv_dly);
            n_vec++;
            if ({bus.mem_req, bus.ex_ready, bus.wb_valid} !== 3'b000) begin
                n_miss++;
                $display("FAIL %s wait cycle %0d: req=%b rdy=%b wbv=%b, want 0 0 0",
                         name, i, bus.mem_req, bus.ex_ready, bus.wb_valid);
            end
            if (i == rv_dly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
            end
            tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
        n_vec++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.ex_ready, bus.mem_req} !==
            {1'b1, rd, exp_data, 1'b1, 1'b0}) begin
            n_miss++;
            $display("FAIL %s writeback: wbv=%b rd=%0d data=%h rdy=%b req=%b, want wbv=1 rd=%0d data=%h rdy=1 req=0",
                     name, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.ex_ready, bus.mem_req,
                     rd, exp_data);
        end
        tick();
        n_vec++;
        if (bus.wb_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL %s wb pulse width: wbv=%b one cycle later, want 0", name, bus.wb_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.wb_valid,
             bus.wb_rd, bus.wb_data, bus.misalign, bus.ex_ready} !==
            {1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL reset: req=%b we=%b be=%b addr=%h wdata=%h wbv=%b rd=%0d data=%h mis=%b rdy=%b, want all zero with rdy=1",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                     bus.wb_valid, bus.wb_rd, bus.wb_data, bus.misalign, bus.ex_ready);
        end
    endtask

    task automatic test_store();
        run_store("sw_0x100",     F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
        run_store("sb_0x301",     F3_B, 32'h0000_0301, 32'h0000_00A5, 0, 4'b0010, 32'hA5A5_A5A5);
        run_store("sh_0x302",     F3_H, 32'h0000_0302, 32'hFFFF_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
        run_store("sw_gnt_delay", F3_W, 32'h0000_0400, 32'h1234_5678, 2, 4'b1111, 32'h1234_5678);
    endtask

    task automatic test_load_byte();
        run_load("lb_0x203",  F3_B,  32'h0000_0203, 32'h80FF_FF7F, 5'd5, 0, 0, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu_0x203", F3_BU, 32'h0000_0203, 32'h80FF_FF7F, 5'd6, 0, 0, 4'b1000, 32'h0000_0080);
        run_load("lb_0x200",  F3_B,  32'h0000_0200, 32'h80FF_FF7F, 5'd1, 0, 0, 4'b0001, 32'h0000_007F);
        run_load("lb_0x201",  F3_B,  32'h0000_0201, 32'h80FF_FF7F, 5'd2, 0, 0, 4'b0010, 32'hFFFF_FFFF);
        run_load("lbu_0x202", F3_BU, 32'h0000_0202, 32'h80FF_FF7F, 5'd3, 0, 0, 4'b0100, 32'h0000_00FF);
    endtask

    task automatic test_load_half_word();
        run_load("lh_0x102",  F3_H,  32'h0000_0102, 32'h8001_1234, 5'd10, 0, 0, 4'b1100, 32'hFFFF_8001);
        run_load("lhu_0x102", F3_HU, 32'h0000_0102, 32'h8001_1234, 5'd11, 0, 0, 4'b1100, 32'h0000_8001);
        run_load("lh_0x100",  F3_H,  32'h0000_0100, 32'h8001_1234, 5'd12, 0, 0, 4'b0011, 32'h0000_1234);
        run_load("lw_0x104",  F3_W,  32'h0000_0104, 32'h1234_5678, 5'd13, 0, 0, 4'b1111, 32'h1234_5678);
    endtask

    task automatic test_misalign();
        logic        mis_store [4];
        logic [2:0]  mis_f3    [4];
        logic [31:0] mis_addr  [4];
        mis_store[0] = 1'b0; mis_f3[0] = F3_W;   mis_addr[0] = 32'h0000_0101;
        mis_store[1] = 1'b0; mis_f3[1] = F3_HU;  mis_addr[1] = 32'h0000_0103;
        mis_store[2] = 1'b1; mis_f3[2] = F3_W;   mis_addr[2] = 32'h0000_0102;
        mis_store[3] = 1'b0; mis_f3[3] = 3'b011; mis_addr[3] = 32'h0000_0100;
        // gnt asserted outside REQ must not matter
        bus.mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.ex_valid    = 1'b1;
            bus.ex_is_store = mis_store[k];
            bus.ex_funct3   = mis_f3[k];
            bus.ex_addr     = mis_addr[k];
            bus.ex_rd       = 5'd9;
            tick();
            bus.ex_valid = 1'b0;
            n_vec++;
            if ({bus.misalign, bus.mem_req, bus.ex_ready, bus.wb_valid} !== 4'b1010) begin
                n_miss++;
                $display("FAIL misalign[%0d] pulse: mis=%b req=%b rdy=%b wbv=%b, want 1 0 1 0",
                         k, bus.misalign, bus.mem_req, bus.ex_ready, bus.wb_valid);
            end
            tick();
            n_vec++;
            if ({bus.misalign, bus.mem_req, bus.ex_ready, bus.wb_valid} !== 4'b0010) begin
                n_miss++;
                $display("FAIL misalign[%0d] after: mis=%b req=%b rdy=%b wbv=%b, want 0 0 1 0",
                         k, bus.misalign, bus.mem_req, bus.ex_ready, bus.wb_valid);
            end
        end
        bus.mem_gnt = 1'b0;
    endtask

    task automatic test_delayed_handshake();
        run_load("lw_slow", F3_W, 32'h0000_0208, 32'hCAFE_F00D, 5'd31, 3, 2, 4'b1111, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_mid_op();
        bus.ex_valid    = 1'b1;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = F3_W;
        bus.ex_addr     = 32'h0000_0400;
        bus.ex_rd       = 5'd7;
        tick();
        bus.ex_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        n_vec++;
        if ({bus.mem_req, bus.ex_ready} !== 2'b00) begin
            n_miss++;
            $display("FAIL rst_mid wait_r: req=%b rdy=%b, want 0 0", bus.mem_req, bus.ex_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.wb_valid,
             bus.wb_rd, bus.wb_data, bus.misalign, bus.ex_ready} !==
            {1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL rst_mid reset values: req=%b we=%b be=%b addr=%h wdata=%h wbv=%b rd=%0d data=%h mis=%b rdy=%b, want all zero with rdy=1",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                     bus.wb_valid, bus.wb_rd, bus.wb_data, bus.misalign, bus.ex_ready);
        end
        // Stale response from the abandoned load
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        tick();
        bus.mem_rvalid = 1'b0;
        n_vec++;
        if ({bus.wb_valid, bus.ex_ready, bus.mem_req, bus.wb_data} !== {3'b010, 32'h0}) begin
            n_miss++;
            $display("FAIL rst_mid stale rvalid: wbv=%b rdy=%b req=%b data=%h, want 0 1 0 00000000",
                     bus.wb_valid, bus.ex_ready, bus.mem_req, bus.wb_data);
        end
        // Unit must still work normally afterwards
        run_load("lb_after_rst", F3_B, 32'h0000_0500, 32'h0000_00F0, 5'd4, 0, 0, 4'b0001, 32'hFFFF_FFF0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.ex_valid    = 1'b0;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = 3'b000;
        bus.ex_addr     = 32'h0;
        bus.ex_wdata    = 32'h0;
        bus.ex_rd       = 5'd0;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'h0;

        test_reset();
        test_store();
        test_load_byte();
        test_load_half_word();
        test_misalign();
        test_delayed_handshake();
        test_reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
